// File: rtl/arbiter_bram_pkg.sv
// Shared widths, types and helpers for the arbitrated BRAM controller.
// Latency: none (package only).
// Backpressure: none (package only).
package arbiter_bram_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 1024;
    localparam int DEF_NUM_CH     = 4;

    // Largest supported channel count and the pointer width that covers it
    localparam int MAX_CH = 16;
    localparam int PTR_W  = 4;

    // Channel-index width; never narrower than one bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Grant vector wide enough for the largest channel count
    typedef logic [MAX_CH-1:0] gnt_vec_t;

    // Channel index / round-robin pointer as seen outside an arbiter
    typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/arbiter_bram_mc_rr_arbiter.sv
// Round-robin arbiter: picks first requester at/after the pointer, registered one-hot grant.
// Latency: grant pulses the cycle after the request is sampled.
// Backpressure: none; a channel granted this cycle is masked so a held request cannot win twice in a row.
module rr_arbiter
    import arbiter_bram_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt,
    output ptr_t              idx,
    output ptr_t              ptr
);

    localparam int                CH_W = clog2(NUM_CH);
    localparam logic [NUM_CH-1:0] ONE  = NUM_CH'(1);

    logic [CH_W-1:0]     ptr_q;
    logic [CH_W-1:0]     win;
    logic [CH_W-1:0]     ptr_nxt;
    logic [NUM_CH-1:0]   eff;
    logic [2*NUM_CH-1:0] rot;
    logic                found;

    // A channel whose grant is showing now sits out this round
    assign eff = req & ~gnt;

    // Rotate so bit 0 is the channel the pointer names; the double copy handles the wrap
    assign rot = {eff, eff} >> ptr_q;

    // Find the first eligible channel at or after the pointer
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                if (int'(ptr_q) + k >= NUM_CH) begin
                    win = CH_W'(int'(ptr_q) + k - NUM_CH);
                end else begin
                    win = CH_W'(int'(ptr_q) + k);
                end
            end
        end
    end

    assign ptr_nxt = (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;

    // Register the grant and move the pointer past the winner; hold it when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt   <= '0;
            idx   <= '0;
            ptr_q <= '0;
        end else if (found) begin
            gnt   <= ONE << win;
            idx   <= ptr_t'(win);
            ptr_q <= ptr_nxt;
        end else begin
            gnt   <= '0;
        end
    end

    assign ptr = ptr_t'(ptr_q);

endmodule

// File: rtl/arbiter_bram_mc.sv
// Multi-channel BRAM front end: round-robin read and write arbitration onto a 1R/1W memory.
// Latency: grant 1 cycle after sampled request, read data 1 cycle after grant; write commits at end of grant cycle.
// Backpressure: requesters hold req (and addr/data) level until their grant pulse. Macro ARBITER_BRAM_FWD_EN: same-edge write data forwarded to read.
module arbiter_bram_mc
    import arbiter_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            rd_req,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_CH-1:0]            rd_gnt,
    output logic [NUM_CH-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    input  logic [NUM_CH-1:0]            wr_req,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_CH-1:0]            wr_gnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    ptr_t rd_idx;
    ptr_t wr_idx;
    ptr_t rd_ptr;
    ptr_t wr_ptr;

    logic                  rd_active;
    logic                  wr_active;
    logic [ADDR_WIDTH-1:0] rd_sel_addr;
    logic [ADDR_WIDTH-1:0] wr_sel_addr;
    logic [DATA_WIDTH-1:0] wr_sel_data;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .gnt (rd_gnt),
        .idx (rd_idx),
        .ptr (rd_ptr)
    );

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .gnt (wr_gnt),
        .idx (wr_idx),
        .ptr (wr_ptr)
    );

    // The granted channel presents its operands during its grant cycle
    assign rd_active   = |rd_gnt;
    assign wr_active   = |wr_gnt;
    assign rd_sel_addr = rd_addr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_sel_addr = wr_addr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_sel_data = wr_data[wr_idx*DATA_WIDTH +: DATA_WIDTH];

    // Write port: commit at the edge ending the grant cycle; a reset on that edge drops it
    always_ff @(posedge clk) begin
        if (!rst && wr_active) begin
            mem[wr_sel_addr] <= wr_sel_data;
        end
    end

    // Read port: valid follows the grant by one cycle; data is held between reads and never reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_gnt;
            if (rd_active) begin
`ifdef ARBITER_BRAM_FWD_EN
                if (wr_active && (wr_sel_addr == rd_sel_addr)) begin
                    rd_data <= wr_sel_data;
                end else begin
                    rd_data <= mem[rd_sel_addr];
                end
`else
                rd_data <= mem[rd_sel_addr];
`endif
            end
        end
    end

    // Round-robin pointers must always name a real channel
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(rd_ptr) < NUM_CH);
            assert (int'(wr_ptr) < NUM_CH);
        end
    end

endmodule

// File: tb/tb_arbiter_bram_mc.sv
// Directed bench for arbiter_bram_mc with hand-computed expectations.
// Latency: checks at 1 ns after each rising edge.
// Backpressure: requests are dropped by the bench once the grant has been seen.
module tb_arbiter_bram_mc;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NC = 4;

    logic             clk;
    logic             rst;
    logic [NC-1:0]    rd_req;
    logic [NC*AW-1:0] rd_addr;
    logic [NC-1:0]    rd_gnt;
    logic [NC-1:0]    rd_valid;
    logic [DW-1:0]    rd_data;
    logic [NC-1:0]    wr_req;
    logic [NC*AW-1:0] wr_addr;
    logic [NC*DW-1:0] wr_data;
    logic [NC-1:0]    wr_gnt;

    int tests_run;
    int tests_failed;

    arbiter_bram_mc #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_CH     (NC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_gnt   (wr_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int c, input logic [AW-1:0] a);
        rd_addr[c*AW +: AW] = a;
    endtask

    task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr[c*AW +: AW] = a;
        wr_data[c*DW +: DW] = d;
    endtask

    logic [NC-1:0] prio_seq [5];
    logic [NC-1:0] solo_seq [6];
    logic [DW-1:0] coll_exp;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst     = 1'b1;
        rd_req  = '0;
        wr_req  = '0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        prio_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        solo_seq = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000};
`ifdef ARBITER_BRAM_FWD_EN
        coll_exp = 8'h22;
`else
        coll_exp = 8'h11;
`endif

        // Reset state
        tick();
        tick();
        check("rst_rd_gnt", 32'(rd_gnt), 32'h0);
        check("rst_wr_gnt", 32'(wr_gnt), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        rst = 1'b0;

        // All four readers requesting: rotation from channel 0, one grant per cycle
        rd_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("prio_%0d", i), 32'(rd_gnt), 32'(prio_seq[i]));
        end
        rd_req = '0;
        tick();
        tick();
        // read pointer now at 1, write pointer at 0

        // ch2 writes 0xA5 to addr 3
        set_wr(2, 4'd3, 8'hA5);
        wr_req = 4'b0100;
        tick();
        check("wr_gnt_ch2", 32'(wr_gnt), 32'h4);
        wr_req = '0;
        tick();
        check("wr_gnt_drop", 32'(wr_gnt), 32'h0);

        // ch1 reads addr 3: grant at t+1, data at t+2
        set_rd(1, 4'd3);
        rd_req = 4'b0010;
        tick();
        check("lat_rd_gnt", 32'(rd_gnt), 32'h2);
        check("lat_no_valid_yet", 32'(rd_valid), 32'h0);
        rd_req = '0;
        tick();
        check("lat_rd_valid", 32'(rd_valid), 32'h2);
        check("lat_rd_data", 32'(rd_data), 32'hA5);
        check("lat_gnt_gone", 32'(rd_gnt), 32'h0);

        // Lone writer on ch3: grants every other cycle
        set_wr(3, 4'd9, 8'h3C);
        wr_req = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("solo_%0d", i), 32'(wr_gnt), 32'(solo_seq[i]));
        end
        wr_req = '0;
        tick();
        // write pointer now at 0, read pointer at 2

        // Preload addr 7 with 0x11
        set_wr(0, 4'd7, 8'h11);
        wr_req = 4'b0001;
        tick();
        check("pre_wr_gnt", 32'(wr_gnt), 32'h1);
        wr_req = '0;
        tick();

        // Same-edge read and write 0x22 to addr 7
        set_rd(0, 4'd7);
        set_wr(1, 4'd7, 8'h22);
        rd_req = 4'b0001;
        wr_req = 4'b0010;
        tick();
        check("coll_rd_gnt", 32'(rd_gnt), 32'h1);
        check("coll_wr_gnt", 32'(wr_gnt), 32'h2);
        rd_req = '0;
        wr_req = '0;
        tick();
        check("coll_rd_valid", 32'(rd_valid), 32'h1);
        check("coll_rd_data", 32'(rd_data), 32'(coll_exp));

        // The colliding write must have landed
        rd_req = 4'b0001;
        tick();
        check("post_rd_gnt", 32'(rd_gnt), 32'h1);
        rd_req = '0;
        tick();
        check("post_rd_data", 32'(rd_data), 32'h22);
        // read pointer at 1, write pointer at 2

        // Reset during the grant cycle of a read (ch2) and a write (ch3 -> addr 3)
        set_rd(2, 4'd3);
        set_wr(3, 4'd3, 8'h5A);
        rd_req = 4'b0100;
        wr_req = 4'b1000;
        tick();
        check("mrst_rd_gnt", 32'(rd_gnt), 32'h4);
        check("mrst_wr_gnt", 32'(wr_gnt), 32'h8);
        rst = 1'b1;
        tick();
        check("mrst_no_valid", 32'(rd_valid), 32'h0);
        check("mrst_rd_gnt_clr", 32'(rd_gnt), 32'h0);
        check("mrst_wr_gnt_clr", 32'(wr_gnt), 32'h0);
        check("mrst_data_held", 32'(rd_data), 32'h22);
        rst    = 1'b0;
        rd_req = '0;
        wr_req = '0;

        // Pointer back at 0: lowest requester (ch1) wins over ch3
        set_rd(1, 4'd3);
        set_rd(3, 4'd3);
        rd_req = 4'b1010;
        tick();
        check("mrst_next_gnt", 32'(rd_gnt), 32'h2);
        rd_req = '0;
        tick();
        check("mrst_next_valid", 32'(rd_valid), 32'h2);
        check("mrst_no_write", 32'(rd_data), 32'hA5);
        // read pointer at 2

        // Wrap: ch3 granted, then ch0 beats ch2
        rd_req = 4'b1000;
        tick();
        check("wrap_ch3", 32'(rd_gnt), 32'h8);
        rd_req = 4'b0101;
        tick();
        check("wrap_ch0", 32'(rd_gnt), 32'h1);
        tick();
        check("wrap_ch2", 32'(rd_gnt), 32'h4);
        rd_req = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
